rx_dwidth_conv: RTL

RX_DWIDTH_CONV -- requirements
Module: rx_dwidth_conv

---
 rtl/rx_dwidth_conv.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/rx_dwidth_conv.sv
// Receive-side width converter: packs RATIO GT words into one frame, hunting for and
// tracking SOF alignment before frames are released downstream.
module rx_dwidth_conv #(
  parameter int unsigned FRAME_WIDTH   = 256,
  parameter int unsigned DWIDTH_IN     = 64,
  parameter int unsigned CNT_WIDTH     = 2,
  parameter int unsigned LOCK_THRESH   = 4,
  parameter int unsigned UNLOCK_THRESH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DWIDTH_IN-1:0]   din,
  input  logic                   din_valid,
  input  logic                   sof_in,
  output logic [FRAME_WIDTH-1:0] dout,
  output logic                   dout_valid,
  output logic [CNT_WIDTH-1:0]   clk_cnt,
  output logic                   locked,
  output logic                   align_err
);

  localparam int unsigned RATIO = 2 ** CNT_WIDTH;
  localparam int unsigned SW    = $clog2(LOCK_THRESH + 1);
  localparam int unsigned MW    = $clog2(UNLOCK_THRESH + 1);

  localparam logic [SW-1:0]        SofLock = SW'(LOCK_THRESH);
  localparam logic [SW-1:0]        SofOne  = SW'(1);
  localparam logic [MW-1:0]        MissMax = MW'(UNLOCK_THRESH);
  localparam logic [MW-1:0]        MissOne = MW'(1);
  localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CntLast = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StCheck  = 2'd1,
    StLocked = 2'd2
  } state_e;

  state_e                 state_q;
  logic [CNT_WIDTH-1:0]   clk_cnt_q;
  logic [SW-1:0]          sof_cnt_q;
  logic [MW-1:0]          miss_cnt_q;
  logic [FRAME_WIDTH-1:0] frame_q;
  logic [FRAME_WIDTH-1:0] dout_q;
  logic                   dout_valid_q;
  logic                   locked_q;
  logic                   align_err_q;

  logic                   at_slot0;
  logic [SW-1:0]          sof_inc;
  logic [MW-1:0]          miss_inc;
  logic                   unlock;
  logic [FRAME_WIDTH-1:0] frame_ins;

  assign at_slot0 = (clk_cnt_q == '0);
  assign sof_inc  = sof_cnt_q + SofOne;
  assign miss_inc = (miss_cnt_q == MissMax) ? miss_cnt_q : miss_cnt_q + MissOne;
  assign unlock   = (miss_inc == MissMax);

  // Frame buffer with the current word dropped into its slot; slot 0 sits at the MSBs.
  always_comb begin
    frame_ins = frame_q;
    for (int k = 0; k < RATIO; k++) begin
      if (clk_cnt_q == CNT_WIDTH'(k)) begin
        frame_ins[FRAME_WIDTH-1-k*DWIDTH_IN -: DWIDTH_IN] = din;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StHunt;
      clk_cnt_q    <= '0;
      sof_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      frame_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      align_err_q  <= 1'b0;
      if (din_valid) begin
        unique case (state_q)
          StHunt: begin
            if (sof_in) begin
              frame_q[FRAME_WIDTH-1 -: DWIDTH_IN] <= din;
              clk_cnt_q <= CntOne;
              sof_cnt_q <= SofOne;
              if (SofOne == SofLock) begin
                state_q    <= StLocked;
                locked_q   <= 1'b1;
                miss_cnt_q <= '0;
              end else begin
                state_q <= StCheck;
              end
            end
          end

          StCheck: begin
            if (sof_in && at_slot0) begin
              frame_q[FRAME_WIDTH-1 -: DWIDTH_IN] <= din;
              clk_cnt_q <= CntOne;
              sof_cnt_q <= sof_inc;
              if (sof_inc == SofLock) begin
                state_q    <= StLocked;
                locked_q   <= 1'b1;
                miss_cnt_q <= '0;
              end
            end else if (sof_in) begin
              // Misplaced SOF: drop back to hunt and take this word as a fresh SOF.
              frame_q[FRAME_WIDTH-1 -: DWIDTH_IN] <= din;
              clk_cnt_q <= CntOne;
              sof_cnt_q <= SofOne;
            end else if (at_slot0) begin
              state_q   <= StHunt;
              clk_cnt_q <= '0;
              sof_cnt_q <= '0;
            end else begin
              frame_q   <= frame_ins;
              clk_cnt_q <= clk_cnt_q + CntOne;
            end
          end

          StLocked: begin
            if (at_slot0 && sof_in) begin
              frame_q[FRAME_WIDTH-1 -: DWIDTH_IN] <= din;
              clk_cnt_q  <= CntOne;
              miss_cnt_q <= '0;
            end else if (at_slot0 || sof_in) begin
              if (unlock) begin
                state_q    <= StHunt;
                locked_q   <= 1'b0;
                align_err_q <= 1'b1;
                clk_cnt_q  <= '0;
                sof_cnt_q  <= '0;
                miss_cnt_q <= '0;
              end else begin
                // Missing or early SOF: restart the frame on this word and note the miss.
                frame_q[FRAME_WIDTH-1 -: DWIDTH_IN] <= din;
                clk_cnt_q  <= CntOne;
                miss_cnt_q <= miss_inc;
              end
            end else begin
              frame_q   <= frame_ins;
              clk_cnt_q <= clk_cnt_q + CntOne;
              if (clk_cnt_q == CntLast) begin
                dout_q       <= frame_ins;
                dout_valid_q <= 1'b1;
              end
            end
          end

          default: begin
            state_q   <= StHunt;
            locked_q  <= 1'b0;
            clk_cnt_q <= '0;
            sof_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign clk_cnt    = clk_cnt_q;
  assign locked     = locked_q;
  assign align_err  = align_err_q;

endmodule
